// File: rtl/status_bar_engine.sv
// status_bar_engine: two-player health bars with a hold-then-drain damage trail, KO flags and a
// registered RGB565 pixel stream. Define STATUS_BAR_LOWHP_FLASH_EN to flash low-health live bars.
module status_bar_engine #(
    parameter int unsigned HEALTH_W   = 5,
    parameter int unsigned MAX_HEALTH = 20,
    parameter int unsigned PX_PER_HP  = 2,
    parameter int unsigned DRAIN_DIV  = 5_000_000,
    parameter int unsigned HOLD_TICKS = 5,
    parameter int unsigned FLASH_DIV  = 12_500_000,
    parameter int unsigned LOW_THRESH = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HEALTH_W-1:0] curr_health_l,
    input  logic [HEALTH_W-1:0] curr_health_r,
    input  logic [12:0]         pixel_index,
    output logic [15:0]         oled_colour,
    output logic [HEALTH_W-1:0] final_health_l,
    output logic [HEALTH_W-1:0] final_health_r,
    output logic                ko_l,
    output logic                ko_r,
    output logic                busy
);

    localparam int unsigned TICK_W  = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
    localparam int unsigned FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam int unsigned HOLD_W  = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HEALTH_W-1:0] MAX_H = HEALTH_W'(MAX_HEALTH);

    if (MAX_HEALTH * PX_PER_HP > 41 || LOW_THRESH >= (1 << HEALTH_W)) begin : g_param_check
        $error("status_bar_engine: bar longer than 41 px or LOW_THRESH wider than HEALTH_W");
    end

    typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_t;

    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [FLASH_W-1:0]  flash_cnt_q, flash_cnt_d;
    logic                flash_q, flash_d;
    logic                tick;
    logic [HEALTH_W-1:0] raw     [2];
    logic [HEALTH_W-1:0] c       [2];
    logic [HEALTH_W-1:0] disp_q  [2];
    logic [HEALTH_W-1:0] disp_d  [2];
    logic [HEALTH_W-1:0] prev_q  [2];
    logic [HEALTH_W-1:0] prev_d  [2];
    logic [HOLD_W-1:0]   hold_q  [2];
    logic [HOLD_W-1:0]   hold_d  [2];
    state_t              state_q [2];
    state_t              state_d [2];
    logic                ko_q    [2];
    logic                ko_d    [2];
    logic [15:0]         colour_q, colour_d;

    logic [6:0]          px_x, px_y;
    logic [6:0]          off     [2];
    logic [6:0]          c_px    [2];
    logic [6:0]          d_px    [2];
    logic                side_on [2];
    logic                live    [2];
    logic                trail   [2];
    logic [15:0]         live_col[2];
    logic                in_rows, in_box;

    assign raw[0] = curr_health_l;
    assign raw[1] = curr_health_r;

    always_comb begin
        tick        = (tick_cnt_q == TICK_W'(DRAIN_DIV - 1));
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TICK_W'(1);
        flash_d     = flash_q;
        flash_cnt_d = flash_cnt_q + FLASH_W'(1);
        if (flash_cnt_q == FLASH_W'(FLASH_DIV - 1)) begin
            flash_cnt_d = '0;
            flash_d     = ~flash_q;
        end
    end

    // A heal (c >= d) overrides every state, so it is tested before the per-state behaviour.
    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            c[s]       = (raw[s] > MAX_H) ? MAX_H : raw[s];
            state_d[s] = state_q[s];
            disp_d[s]  = disp_q[s];
            hold_d[s]  = hold_q[s];
            prev_d[s]  = c[s];
            ko_d[s]    = ko_q[s];
            if (c[s] >= disp_q[s]) begin
                disp_d[s]  = c[s];
                hold_d[s]  = '0;
                state_d[s] = IDLE;
            end else begin
                unique case (state_q[s])
                    IDLE: begin
                        state_d[s] = HOLD;
                        hold_d[s]  = '0;
                    end
                    HOLD: begin
                        if (c[s] < prev_q[s]) begin
                            hold_d[s] = '0;
                        end else if (tick) begin
                            hold_d[s] = hold_q[s] + HOLD_W'(1);
                            if (hold_q[s] == HOLD_W'(HOLD_TICKS - 1)) state_d[s] = DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (tick) begin
                            disp_d[s] = disp_q[s] - HEALTH_W'(1);
                            if (disp_q[s] - HEALTH_W'(1) == c[s]) state_d[s] = IDLE;
                        end
                    end
                    default: state_d[s] = IDLE;
                endcase
            end
            if (c[s] != '0) begin
                ko_d[s] = 1'b0;
            end else if (disp_q[s] == '0 && state_q[s] == IDLE) begin
                ko_d[s] = 1'b1;
            end
        end
    end

    // Left bar grows leftward from x=40, right bar rightward from x=55; offsets are only valid
    // on the matching side of the screen, which side_on enforces.
    always_comb begin
        px_x       = 7'(pixel_index % 13'd96);
        px_y       = 7'(pixel_index / 13'd96);
        in_rows    = (px_y >= 7'd3) && (px_y <= 7'd6);
        in_box     = (px_x >= 7'd42) && (px_x <= 7'd53) && (px_y >= 7'd2) && (px_y <= 7'd9);
        off[0]     = 7'd40 - px_x;
        off[1]     = px_x - 7'd55;
        side_on[0] = in_rows && (px_x <= 7'd40);
        side_on[1] = in_rows && (px_x >= 7'd55);
        for (int unsigned s = 0; s < 2; s++) begin
            c_px[s]  = 7'(c[s]) * 7'(PX_PER_HP);
            d_px[s]  = 7'(disp_q[s]) * 7'(PX_PER_HP);
            live[s]  = side_on[s] && (off[s] < c_px[s]);
            trail[s] = side_on[s] && (off[s] >= c_px[s]) && (off[s] < d_px[s]);
`ifdef STATUS_BAR_LOWHP_FLASH_EN
            live_col[s] = ((c[s] != '0) && (c[s] <= HEALTH_W'(LOW_THRESH)) && flash_q)
                          ? 16'hFFFF : 16'hFFE0;
`else
            live_col[s] = 16'hFFE0;
`endif
        end
        colour_d = '0;
        if (in_box) begin
            colour_d = ((ko_q[0] || ko_q[1]) && flash_q) ? 16'hFFFF : 16'hF800;
        end else if (live[0]) begin
            colour_d = live_col[0];
        end else if (live[1]) begin
            colour_d = live_col[1];
        end else if (trail[0] || trail[1]) begin
            colour_d = 16'hF800;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            flash_cnt_q <= '0;
            flash_q     <= 1'b0;
            colour_q    <= '0;
            for (int unsigned s = 0; s < 2; s++) begin
                disp_q[s]  <= MAX_H;
                prev_q[s]  <= MAX_H;
                hold_q[s]  <= '0;
                state_q[s] <= IDLE;
                ko_q[s]    <= 1'b0;
            end
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            flash_q     <= flash_d;
            colour_q    <= colour_d;
            for (int unsigned s = 0; s < 2; s++) begin
                disp_q[s]  <= disp_d[s];
                prev_q[s]  <= prev_d[s];
                hold_q[s]  <= hold_d[s];
                state_q[s] <= state_d[s];
                ko_q[s]    <= ko_d[s];
            end
        end
    end

    assign oled_colour    = colour_q;
    assign final_health_l = disp_q[0];
    assign final_health_r = disp_q[1];
    assign ko_l           = ko_q[0];
    assign ko_r           = ko_q[1];
    assign busy           = (state_q[0] != IDLE) || (state_q[1] != IDLE);

endmodule
